// File: rtl/final_design.sv
// Minimal 16-bit load/store core: host downloads a program into IMEM, then the
// core executes one instruction per clock until pc runs past the program end.
module final_design #(
    parameter int DATA_W     = 16,
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256,
    parameter int NREGS      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  valid,
    input  logic [15:0] instruction,
    input  logic [7:0]  instruction_address,
    output logic [7:0]  pc,
    output logic        running,
    output logic        halted,
    output logic        wb_en,
    output logic [3:0]  wb_addr,
    output logic [15:0] wb_data,
    output logic [15:0] alu_result,
    output logic        zero
);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] imem [IMEM_DEPTH];
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];
    logic [DATA_W-1:0] rf   [NREGS];

    // One past the highest address written; 9 bits so address 255 can end a program.
    logic [8:0]  prog_end;
    logic [8:0]  load_end;

    logic [15:0] ir;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [7:0]  k;
    logic        exec;
    logic [15:0] sum;
    logic [15:0] diff;

    assign ir       = imem[pc];
    assign op       = ir[15:12];
    assign rd       = ir[11:8];
    assign ra       = ir[7:4];
    assign rb       = ir[3:0];
    assign k        = ir[7:0];
    assign exec     = (state == ST_RUN) && ({1'b0, pc} < prog_end);
    assign sum      = rf[ra] + rf[rb];
    assign diff     = rf[ra] - rf[rb];
    assign load_end = {1'b0, instruction_address} + 9'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD: if (valid == 2'b11) state_next = ST_RUN;
            ST_RUN:  if (!exec || op > 4'h5) state_next = ST_HALT;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_LOAD;
        endcase
    end

    always_comb begin
        running = (state == ST_RUN);
        halted  = (state == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < IMEM_DEPTH; i++) imem[i[7:0]] <= '0;
            for (int unsigned i = 0; i < DMEM_DEPTH; i++) dmem[i[7:0]] <= '0;
            for (int unsigned i = 0; i < NREGS; i++)      rf[i[3:0]]   <= '0;
            pc         <= '0;
            prog_end   <= '0;
            wb_en      <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            alu_result <= '0;
            zero       <= 1'b0;
        end else begin
            wb_en <= 1'b0;
            if (state == ST_LOAD) begin
                if (valid == 2'b01) begin
                    imem[instruction_address] <= instruction;
                    if (load_end > prog_end) prog_end <= load_end;
                end else if (valid == 2'b11) begin
                    pc <= '0;
                end
            end else if (exec) begin
                case (op)
                    4'h0: begin
                        rf[rd]  <= dmem[k];
                        wb_en   <= 1'b1;
                        wb_addr <= rd;
                        wb_data <= dmem[k];
                        pc      <= pc + 8'd1;
                    end
                    4'h1: begin
                        dmem[k] <= rf[rd];
                        pc      <= pc + 8'd1;
                    end
                    4'h2: begin
                        rf[rd]     <= sum;
                        wb_en      <= 1'b1;
                        wb_addr    <= rd;
                        wb_data    <= sum;
                        alu_result <= sum;
                        zero       <= (sum == '0);
                        pc         <= pc + 8'd1;
                    end
                    4'h3: begin
                        rf[rd]  <= {8'h00, k};
                        wb_en   <= 1'b1;
                        wb_addr <= rd;
                        wb_data <= {8'h00, k};
                        pc      <= pc + 8'd1;
                    end
                    4'h4: begin
                        rf[rd]     <= diff;
                        wb_en      <= 1'b1;
                        wb_addr    <= rd;
                        wb_data    <= diff;
                        alu_result <= diff;
                        zero       <= (diff == '0);
                        pc         <= pc + 8'd1;
                    end
                    // 8-bit add of k is the sign-extended offset taken mod 256.
                    4'h5: pc <= (rf[rd] == '0) ? pc + k : pc + 8'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_final_design.sv
// Scoreboarded bench for final_design: expected register writebacks are queued
// per program and a negedge monitor pops and compares them as wb_en fires.
module tb_final_design;

    logic        clk;
    logic        reset;
    logic [1:0]  valid;
    logic [15:0] instruction;
    logic [7:0]  instruction_address;
    logic [7:0]  pc;
    logic        running;
    logic        halted;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic [15:0] alu_result;
    logic        zero;

    final_design #(
        .DATA_W(16),
        .IMEM_DEPTH(256),
        .DMEM_DEPTH(256),
        .NREGS(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .valid(valid),
        .instruction(instruction),
        .instruction_address(instruction_address),
        .pc(pc),
        .running(running),
        .halted(halted),
        .wb_en(wb_en),
        .wb_addr(wb_addr),
        .wb_data(wb_data),
        .alu_result(alu_result),
        .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
    } wb_t;

    wb_t exp_q[$];
    wb_t mon_e;
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && wb_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got r%0d=%h expected no writeback", wb_addr, wb_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_addr", 32'(wb_addr), 32'(mon_e.addr));
                check("wb_data", 32'(wb_data), 32'(mon_e.data));
            end
        end
    end

    task automatic push(input logic [3:0] a, input logic [15:0] d);
        wb_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        valid = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] instr);
        @(negedge clk);
        valid               = 2'b01;
        instruction_address = a;
        instruction         = instr;
        @(negedge clk);
        valid = 2'b00;
    endtask

    task automatic start();
        @(negedge clk);
        valid = 2'b11;
        @(negedge clk);
        valid = 2'b00;
    endtask

    // Edges counted after the start edge until halted is seen, including the halting edge.
    task automatic run_to_halt(input string name, input int exp_cycles, input logic [7:0] exp_pc);
        int n;
        start();
        n = 0;
        while (halted !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({name, "_halted"}, 32'(halted), 32'd1);
        check({name, "_cycles"}, 32'(n), 32'(exp_cycles));
        check({name, "_pc"}, 32'(pc), 32'(exp_pc));
        @(negedge clk);
        check({name, "_wb_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_running"}, 32'(running), 32'd0);
    endtask

    initial begin
        reset               = 1'b1;
        valid               = 2'b00;
        instruction         = '0;
        instruction_address = '0;

        do_reset();
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_wb_en", 32'(wb_en), 32'd0);
        check("rst_alu", 32'(alu_result), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);

        // Main program, JZ taken from 7 to 9.
        load(8'd0, 16'h3001); load(8'd0, 16'h3001); load(8'd1, 16'h1000);
        load(8'd2, 16'h3102); load(8'd3, 16'h1101); load(8'd4, 16'h0200);
        load(8'd5, 16'h2321); load(8'd6, 16'h3500); load(8'd7, 16'h5502);
        load(8'd8, 16'h3000); load(8'd9, 16'h4423);
        push(4'd0, 16'h0001); push(4'd1, 16'h0002); push(4'd2, 16'h0001);
        push(4'd3, 16'h0003); push(4'd5, 16'h0000); push(4'd4, 16'hFFFE);
        run_to_halt("main", 10, 8'd10);
        check("main_alu", 32'(alu_result), 32'h0000FFFE);
        check("main_zero", 32'(zero), 32'd0);

        // JZ not taken.
        do_reset();
        load(8'd0, 16'h3001); load(8'd1, 16'h1000); load(8'd2, 16'h3102);
        load(8'd3, 16'h1101); load(8'd4, 16'h0200); load(8'd5, 16'h2321);
        load(8'd6, 16'h3501); load(8'd7, 16'h5502); load(8'd8, 16'h3000);
        load(8'd9, 16'h4423);
        push(4'd0, 16'h0001); push(4'd1, 16'h0002); push(4'd2, 16'h0001);
        push(4'd3, 16'h0003); push(4'd5, 16'h0001); push(4'd0, 16'h0000);
        push(4'd4, 16'hFFFE);
        run_to_halt("jz_nt", 11, 8'd10);

        // JZ backward offset 0xFE at pc 3 loops once to pc 1.
        do_reset();
        load(8'd0, 16'h3000); load(8'd1, 16'h2001); load(8'd2, 16'h3101);
        load(8'd3, 16'h50FE);
        push(4'd0, 16'h0000); push(4'd0, 16'h0000); push(4'd1, 16'h0001);
        push(4'd0, 16'h0001); push(4'd1, 16'h0001);
        run_to_halt("jz_back", 8, 8'd4);
        check("jz_back_alu", 32'(alu_result), 32'd1);
        check("jz_back_zero", 32'(zero), 32'd0);

        // JZ wrap 0 + 0xFF lands on 255, past prog_end.
        do_reset();
        load(8'd0, 16'h50FF);
        run_to_halt("jz_wrap", 2, 8'd255);

        // ADD overflow 0x00FF + 0xFF01.
        do_reset();
        load(8'd0, 16'h30FF); load(8'd1, 16'h4110); load(8'd2, 16'h2201);
        push(4'd0, 16'h00FF); push(4'd1, 16'hFF01); push(4'd2, 16'h0000);
        run_to_halt("add_ovf", 4, 8'd3);
        check("add_ovf_alu", 32'(alu_result), 32'd0);
        check("add_ovf_zero", 32'(zero), 32'd1);

        // Undefined opcode halts on the first RUN edge.
        do_reset();
        load(8'd0, 16'h7000);
        run_to_halt("undef", 1, 8'd0);
        check("undef_alu", 32'(alu_result), 32'd0);

        // Spin at pc 2, try an IMEM write while running, then reset mid-run.
        do_reset();
        load(8'd0, 16'h3007); load(8'd1, 16'h1000); load(8'd2, 16'h5100);
        push(4'd0, 16'h0007);
        start();
        repeat (4) @(negedge clk);
        valid               = 2'b01;
        instruction_address = 8'd2;
        instruction         = 16'h7000;
        @(negedge clk);
        valid = 2'b00;
        repeat (4) @(negedge clk);
        check("spin_running", 32'(running), 32'd1);
        check("spin_halted", 32'(halted), 32'd0);
        check("spin_pc", 32'(pc), 32'd2);
        check("spin_wb_left", 32'(exp_q.size()), 32'd0);
        do_reset();
        check("midrst_pc", 32'(pc), 32'd0);
        check("midrst_running", 32'(running), 32'd0);
        check("midrst_halted", 32'(halted), 32'd0);
        check("midrst_alu", 32'(alu_result), 32'd0);

        // IMEM[0] must be cleared (LOAD r0,D0) and D0 cleared, RF cleared.
        load(8'd1, 16'h2223);
        push(4'd0, 16'h0000); push(4'd2, 16'h0000);
        run_to_halt("postrst", 3, 8'd2);
        check("postrst_zero", 32'(zero), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/final_design.md
Name: final_design

Overview:
- Minimal 16-bit load/store processor with on-chip instruction memory (IMEM), data memory (DMEM) and a 16-entry register file.
- A host first downloads the program one instruction at a time (valid=2'b01), then starts execution (valid=2'b11).
- The core executes one instruction per clock until the program ends, then halts.
- Top-level CPU block; the only external visibility is through the debug/status outputs.

Parameters:
- DATA_W, 16, register/memory word width
- IMEM_DEPTH, 256, instruction words (8-bit address)
- DMEM_DEPTH, 256, data words (8-bit address)
- NREGS, 16, register file entries (4-bit index)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- valid  input  2  host command: 00/10 none, 01 write instruction, 11 start/run
- instruction  input  16  instruction word written when valid=01
- instruction_address  input  8  IMEM write address when valid=01
- pc  output  8  current program counter
- running  output  1  core is in RUN state
- halted  output  1  core is in HALT state
- wb_en  output  1  registered; 1 for the cycle after an RF write
- wb_addr  output  4  RF index of last write
- wb_data  output  16  value of last RF write
- alu_result  output  16  result of last ADD/SUB
- zero  output  1  1 when last ADD/SUB result was 0

Behaviour:
- Reset: IMEM, DMEM and RF cleared to 0; state=LOAD; pc=0; prog_end=0; all outputs 0.
- LOAD state:
  - valid=01 → IMEM[instruction_address]=instruction.
  - prog_end=max(prog_end, instruction_address+1), 9-bit.
  - Rewriting the same address overwrites it.
- LOAD state, valid=11 → state=RUN, pc=0; no instruction executes on that edge.
- RUN state:
  - One instruction executes per rising edge: fetch IMEM[pc] combinationally, then execute and update pc.
  - valid is ignored, including 01 (no IMEM writes while running).
- Halt: if pc ≥ prog_end at an edge in RUN → state=HALT, nothing executes. HALT is held until reset.
- Encoding: op=[15:12], r=[11:8], a=[7:4], b=[3:0], k=[7:0].
  - 0000 LOAD: RF[r]=DMEM[k]; pc+1.
  - 0001 STORE: DMEM[k]=RF[r]; pc+1.
  - 0010 ADD: RF[r]=RF[a]+RF[b], mod 2^16; alu_result/zero updated; pc+1.
  - 0011 LOADC: RF[r]={8'h00,k}; pc+1.
  - 0100 SUB: RF[r]=RF[a]-RF[b], two's complement mod 2^16; alu_result/zero updated; pc+1.
  - 0101 JZ: if RF[r]==0, pc=pc+sign_ext(k) mod 256, else pc+1. No RF write.
  - 0110–1111: undefined; state=HALT, no state change.
- Register reads see values from before the current edge (write-first not required; one instruction per cycle, so no hazard).
- wb_en/wb_addr/wb_data update for LOAD/ADD/LOADC/SUB; wb_en=0 otherwise.
- Memory addresses are 8-bit, so there is no out-of-range case. JZ targets wrap mod 256, and a wrapped target ≥ prog_end halts.
- Reset mid-RUN returns to LOAD with everything cleared, identical to power-up.

Test Plan:
- Load program:
  - 0:3001, 0:3001 (rewrite), 1:1000, 2:3102, 3:1101, 4:0200, 5:2321, 6:3500, 7:5502, 8:3000, 9:4423.
  - Then valid=11.
  - Expect: RF0=1, D0=1, RF1=2, D1=2, RF2=1, RF3=3 (alu_result=3, zero=0), RF5=0.
  - JZ jumps pc 7→9, so address 8 is skipped and RF0 stays 1.
  - RF4=0xFFFE, alu_result=0xFFFE.
  - halted=1 with pc=10, after exactly 10 execute cycles.
- JZ not taken: RF5=1 before JZ → address 8 executes, RF0=0, then SUB; halt at pc=10.
- JZ negative offset: k=0xFE at pc=3 with register 0 → pc=1. Verify loop behaviour, and wrap 0+0xFF→255 halts when prog_end ≤255.
- ADD overflow 0xFFFF+1: ADD with operands 0x00FF+0xFF01 → result 0x0000, zero=1.
- Undefined opcode 0x7000 at address 0 → halted=1 after one RUN edge, no RF/DMEM change.
- Reset during RUN: all RF/DMEM/IMEM read 0, state LOAD. valid=01 during RUN is ignored (IMEM unchanged).
